// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Wishbone bus watchdog between an arbiter slave port and one
//               slave. If the slave leaves a request unanswered for TIMEOUT
//               cycles, the access is aborted with a one-cycle error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int aw      = 32,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // master side (from arbiter)
    input  logic [aw-1:0]   wbm_adr_i,
    input  logic [dw-1:0]   wbm_dat_i,
    input  logic [3:0]      wbm_sel_i,
    input  logic            wbm_we_i,
    input  logic            wbm_cyc_i,
    input  logic            wbm_stb_i,
    input  logic [2:0]      wbm_cti_i,
    input  logic [1:0]      wbm_bte_i,
    output logic [dw-1:0]   wbm_dat_o,
    output logic            wbm_ack_o,
    output logic            wbm_err_o,
    output logic            wbm_rty_o,
    // slave side
    output logic [aw-1:0]   wbs_adr_o,
    output logic [dw-1:0]   wbs_dat_o,
    output logic [3:0]      wbs_sel_o,
    output logic            wbs_we_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic [2:0]      wbs_cti_o,
    output logic [1:0]      wbs_bte_o,
    input  logic [dw-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    input  logic            wbs_rty_i,
    // status
    output logic            timeout_o,
    output logic [15:0]     timeout_count_o
);

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    localparam int          CW       = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_ABORT = ST_ABORT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   tcount_q;

    logic w_req;
    logic w_term;
    logic w_abort;

    assign w_req   = wbm_cyc_i & wbm_stb_i;
    assign w_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // Reset masks a pending abort so the master never sees a stale error.
    assign w_abort = (state_q == S_ABORT) && !wb_rst_i;

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;
    assign wbm_dat_o = wbs_dat_i;

    assign wbs_cyc_o = wbm_cyc_i & ~w_abort;
    assign wbs_stb_o = wbm_stb_i & ~w_abort;
    assign wbm_ack_o = wbs_ack_i & ~w_abort;
    assign wbm_rty_o = wbs_rty_i & ~w_abort;
    assign wbm_err_o = wbs_err_i | w_abort;

    assign timeout_o       = w_abort;
    assign timeout_count_o = tcount_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tcount_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req && !w_term) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_term || !w_req) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ABORT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    if (tcount_q != 16'hFFFF)
                        tcount_q <= tcount_q + 16'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_watchdog
// Description : Directed self-checking bench for wb_watchdog with TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_watchdog;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat_w;
    logic [3:0]    m_sel;
    logic          m_we, m_cyc, m_stb;
    logic [2:0]    m_cti;
    logic [1:0]    m_bte;
    logic [DW-1:0] m_dat_r;
    logic          m_ack, m_err, m_rty;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [3:0]    s_sel;
    logic          s_we, s_cyc, s_stb;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [DW-1:0] s_dat_r;
    logic          s_ack, s_err, s_rty;
    logic          tmo;
    logic [15:0]   tcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_watchdog #(.aw(AW), .dw(DW), .TIMEOUT(4)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat_w), .wbm_sel_i(m_sel),
        .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_r), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_w), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_r), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .timeout_o(tmo), .timeout_count_o(tcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input logic v);
        m_cyc = v;
        m_stb = v;
    endtask

    task automatic idle_gap();
        set_req(1'b0);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (2) next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 1'b0;
        m_cti = '0; m_bte = '0;
        set_req(1'b0);
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

        repeat (3) next_cycle();
        settle();
        check("rst_timeout", {31'd0, tmo}, 32'd0);
        check("rst_count", {16'd0, tcnt}, 32'd0);
        check("rst_err", {31'd0, m_err}, 32'd0);
        rst = 1'b0;
        next_cycle();

        // pass-through paths
        m_adr = 32'hDEAD_BEEF; m_dat_w = 32'h1234_5678; m_sel = 4'hA;
        m_we = 1'b1; m_cti = 3'd2; m_bte = 2'd1; s_dat_r = 32'hCAFE_F00D;
        m_cyc = 1'b1; m_stb = 1'b0;
        settle();
        check("pt_adr", s_adr, 32'hDEAD_BEEF);
        check("pt_datw", s_dat_w, 32'h1234_5678);
        check("pt_misc", {22'd0, s_sel, s_we, s_cti, s_bte}, {22'd0, 4'hA, 1'b1, 3'd2, 2'd1});
        check("pt_datr", m_dat_r, 32'hCAFE_F00D);
        check("pt_cyc", {30'd0, s_cyc, s_stb}, 32'd2);
        idle_gap();

        // slave acks in cycle 2
        set_req(1'b1);
        settle();
        check("ack2_c0_stb", {31'd0, s_stb}, 32'd1);
        next_cycle();
        next_cycle();
        s_ack = 1'b1;
        settle();
        check("ack2_ack", {31'd0, m_ack}, 32'd1);
        check("ack2_err", {31'd0, m_err}, 32'd0);
        idle_gap();
        settle();
        check("ack2_count", {16'd0, tcnt}, 32'd0);

        // slave never responds: abort in cycle 4
        set_req(1'b1);
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("stuck_c%0d_err", c), {30'd0, m_err, tmo}, 32'd0);
            next_cycle();
        end
        settle();
        check("stuck_c4_err_tmo", {30'd0, m_err, tmo}, 32'd3);
        check("stuck_c4_cyc", {30'd0, s_cyc, s_stb}, 32'd0);
        set_req(1'b0);
        next_cycle();
        settle();
        check("stuck_c5_tmo", {31'd0, tmo}, 32'd0);
        check("stuck_count", {16'd0, tcnt}, 32'd1);
        idle_gap();

        // ack in cycle 3 (cnt==TIMEOUT-1) wins over abort
        set_req(1'b1);
        repeat (3) next_cycle();
        s_ack = 1'b1;
        settle();
        check("race_ack", {31'd0, m_ack}, 32'd1);
        check("race_err", {31'd0, m_err}, 32'd0);
        set_req(1'b0);
        s_ack = 1'b0;
        next_cycle();
        settle();
        check("race_c4_tmo", {31'd0, tmo}, 32'd0);
        check("race_count", {16'd0, tcnt}, 32'd1);
        idle_gap();

        // late ack during abort is swallowed
        set_req(1'b1);
        repeat (4) next_cycle();
        s_ack = 1'b1;
        settle();
        check("late_ack", {31'd0, m_ack}, 32'd0);
        check("late_err", {31'd0, m_err}, 32'd1);
        set_req(1'b0);
        s_ack = 1'b0;
        next_cycle();
        settle();
        check("late_err_c5", {31'd0, m_err}, 32'd0);
        check("late_count", {16'd0, tcnt}, 32'd2);
        idle_gap();

        // master drops cyc in cycle 2 of WAIT
        set_req(1'b1);
        repeat (2) next_cycle();
        m_cyc = 1'b0;
        for (int c = 2; c < 7; c++) begin
            settle();
            check($sformatf("drop_c%0d", c), {30'd0, m_err, tmo}, 32'd0);
            next_cycle();
        end
        check("drop_count", {16'd0, tcnt}, 32'd2);
        idle_gap();

        // reset in cycle 2 of a stuck access
        set_req(1'b1);
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_req(1'b0);
        for (int c = 3; c < 8; c++) begin
            settle();
            check($sformatf("rstw_c%0d", c), {30'd0, m_err, tmo}, 32'd0);
            next_cycle();
        end
        check("rstw_count", {16'd0, tcnt}, 32'd0);

        // reset held during the abort cycle masks the error
        set_req(1'b1);
        repeat (4) next_cycle();
        rst = 1'b1;
        settle();
        check("rsta_err", {30'd0, m_err, tmo}, 32'd0);
        check("rsta_cyc", {31'd0, s_cyc}, 32'd1);
        next_cycle();
        rst = 1'b0;
        set_req(1'b0);
        settle();
        check("rsta_after", {30'd0, m_err, tmo}, 32'd0);
        check("rsta_count", {16'd0, tcnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_watchdog.md
WB_WATCHDOG -- requirements
Module: wb_watchdog

Interface
REQ-001 SHALL have parameter aw, default 32, address width.
REQ-002 SHALL have parameter dw, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, number of unanswered cycles before abort; legal range 2..65535.
REQ-004 SHALL have port wb_clk_i  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have master-side inputs wbm_adr_i[aw], wbm_dat_i[dw], wbm_sel_i[4], wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i[3], wbm_bte_i[2], driven by the arbiter's slave port.
REQ-007 SHALL have master-side outputs wbm_dat_o[dw], wbm_ack_o, wbm_err_o, wbm_rty_o, returned to the arbiter.
REQ-008 SHALL have slave-side outputs wbs_adr_o[aw], wbs_dat_o[dw], wbs_sel_o[4], wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o[3], wbs_bte_o[2].
REQ-009 SHALL have slave-side inputs wbs_dat_i[dw], wbs_ack_i, wbs_err_i, wbs_rty_i.
REQ-010 SHALL have timeout_o  output  1  one-cycle pulse per abort.
REQ-011 SHALL have timeout_count_o  output  16  saturating abort counter.

Function
REQ-012 SHALL pass adr/dat/sel/we/cti/bte to wbs_* and wbs_dat_i to wbm_dat_o combinationally in all states, zero latency.
REQ-013 SHALL implement FSM states IDLE, WAIT, ABORT.
REQ-014 In IDLE/WAIT: wbs_cyc_o=wbm_cyc_i, wbs_stb_o=wbm_stb_i, wbm_ack/err/rty_o = wbs_ack/err/rty_i combinationally.
REQ-015 "req" = wbm_cyc_i&wbm_stb_i; "term" = wbs_ack_i|wbs_err_i|wbs_rty_i.
REQ-016 IDLE: req&!term -> WAIT with cnt<=1; otherwise stay IDLE, cnt<=0.
REQ-017 WAIT: term or !req -> IDLE, cnt<=0; else cnt==TIMEOUT-1 -> ABORT; else cnt<=cnt+1.
REQ-018 ABORT (exactly one cycle): wbs_cyc_o=wbs_stb_o=0, wbm_err_o=1, wbm_ack_o=wbm_rty_o=0, timeout_o=1; next state IDLE, cnt<=0.
REQ-019 Net effect: wbm_err_o asserts in the cycle exactly TIMEOUT cycles after req first sampled high with no term in between.
REQ-020 term in the same cycle cnt==TIMEOUT-1 SHALL win: normal response forwarded, no abort.
REQ-021 Late slave ack/err/rty during ABORT SHALL be discarded, never forwarded.
REQ-022 Master dropping cyc or stb in WAIT SHALL return to IDLE silently, no err, counter unaffected.
REQ-023 Bursts: each ack'd beat SHALL restart the timer (cti ignored by FSM).
REQ-024 timeout_count_o SHALL increment on each ABORT cycle, saturating at 16'hFFFF.
REQ-025 cnt width SHALL be clog2(TIMEOUT+1) bits; no wrap can occur within legal range.

Reset
REQ-026 On wb_rst_i high at a clock edge: state<=IDLE, cnt<=0, timeout_count_o<=0.
REQ-027 During reset timeout_o=0 and FSM-gated outputs follow IDLE rules; pass-through outputs remain combinational.
REQ-028 Reset asserted mid-WAIT or in ABORT SHALL abandon the pending abort; no err emitted after reset releases.

Structure
REQ-029 No shared package; state encoding and counter width SHALL be module-local localparams; clog2 as a local constant function.
REQ-030 Single flat module; no sub-module needed.
REQ-031 Drop-in between wb_arbiter slave port and a single slave, port widths identical to that interface.

Verification
REQ-032 TIMEOUT=4, slave acks 2 cycles after stb -> ack forwarded, no err, timeout_count_o=0.
REQ-033 TIMEOUT=4, slave never responds -> wbm_err_o and timeout_o high exactly in 5th cycle (cycle 4 from stb), wbs_cyc_o low that cycle, timeout_count_o=1 afterwards.
REQ-034 TIMEOUT=4, slave acks in cycle 3 (cnt==3) -> ack forwarded, no err.
REQ-035 TIMEOUT=4, slave acks in abort cycle -> wbm_ack_o stays 0, wbm_err_o=1 for one cycle.
REQ-036 Master drops cyc in cycle 2 of WAIT -> state IDLE, no err; reset pulsed in cycle 2 of a stuck access -> no err after release, timeout_count_o=0.
REQ-037 Arbiter bench with 5 masters, slave stalled forever on master 2's range -> all other masters complete 1000 transactions; timeout_count_o equals master 2's err count.
